pcs_rx_block_sync: RTL and testbench

Parametrised successor to the PCS RX lock path. It performs 64b/66b block lock over a 32- or 64-bit transceiver word stream and tracks word phase within each 66b block. It drives gearbox slip with a settle hold-off and adds a BER monitor that raises hi_ber. It sits between the external RX gearbox outputs and the descrambler/decoder; the decoder qualifies on block_lock and hi_ber.

---
 rtl/pcs_rx_block_sync.sv | 236 +++++++++++++++++++++++
 tb/tb_pcs_rx_block_sync.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_rx_block_sync.sv
// 64b/66b RX block lock, word-phase tracking, gearbox slip control and BER monitor.
// Optional lock statistics counters are built when PCS_LOCK_STATS_EN is defined.
module pcs_rx_block_sync #(
    parameter int DATA_WIDTH     = 32,
    parameter int LOCK_COUNT     = 64,
    parameter int UNLOCK_INVALID = 16,
    parameter int SLIP_WAIT      = 32,
    parameter int BER_WINDOW     = 20000,
    parameter int BER_THRESHOLD  = 16
) (
    input  logic        xver_rx_clk,
    input  logic        rx_reset,
    input  logic [1:0]  i_header,
    input  logic        i_valid,
    output logic        o_slip,
    output logic        o_block_lock,
    output logic        o_hi_ber,
    output logic        o_block_start,
    output logic [7:0]  o_ber_count,
    input  logic        i_ber_count_clr,
    output logic [15:0] o_slip_count,
    output logic [15:0] o_lock_loss_count
);

    localparam int SH_W  = $clog2(LOCK_COUNT + 1);
    localparam int IV_W  = $clog2(UNLOCK_INVALID + 1);
    localparam int WT_W  = $clog2(SLIP_WAIT + 1);
    localparam int WIN_W = (BER_WINDOW > 1) ? $clog2(BER_WINDOW) : 1;
    localparam int BER_W = $clog2(BER_THRESHOLD + 1);

    typedef enum logic [1:0] {
        LOCK_INIT,
        TEST_SH,
        SLIP,
        WAIT
    } state_t;

    state_t           state_reg, state_next;
    logic [SH_W-1:0]  sh_cnt_reg, sh_cnt_next;
    logic [IV_W-1:0]  sh_invld_cnt_reg, sh_invld_cnt_next;
    logic [WT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic             lock_reg, lock_next;
    logic             slip_reg, slip_next;
    logic [WIN_W-1:0] win_cnt_reg, win_cnt_next;
    logic [BER_W-1:0] ber_cnt_reg, ber_cnt_next;
    logic             hi_ber_reg, hi_ber_next;
    logic [BER_W-1:0] ber_sum;
    logic [7:0]       ber_count_reg;
    logic             block_start;
    logic             hdr_eval;
    logic             hdr_bad;

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
            $error("pcs_rx_block_sync: DATA_WIDTH must be 32 or 64");
        end

        if (DATA_WIDTH == 64) begin : g_w64
            assign block_start = 1'b1;
        end else begin : g_w32
            // Two 32b words per 66b block; realigned to a block boundary by each slip.
            logic phase_reg;
            always_ff @(posedge xver_rx_clk) begin
                if (rx_reset) begin
                    phase_reg <= 1'b0;
                end else if (slip_reg) begin
                    phase_reg <= 1'b0;
                end else if (i_valid) begin
                    phase_reg <= ~phase_reg;
                end
            end
            assign block_start = ~phase_reg;
        end
    endgenerate

    assign hdr_eval = i_valid & block_start;
    assign hdr_bad  = hdr_eval & ~((i_header == 2'b01) | (i_header == 2'b10));

    always_comb begin
        state_next        = state_reg;
        sh_cnt_next       = sh_cnt_reg;
        sh_invld_cnt_next = sh_invld_cnt_reg;
        wait_cnt_next     = wait_cnt_reg;
        lock_next         = lock_reg;
        slip_next         = 1'b0;
        case (state_reg)
            LOCK_INIT: begin
                state_next        = TEST_SH;
                sh_cnt_next       = '0;
                sh_invld_cnt_next = '0;
            end
            TEST_SH: begin
                if (hdr_eval) begin
                    if (!lock_reg) begin
                        if (hdr_bad) begin
                            state_next        = SLIP;
                            slip_next         = 1'b1;
                            sh_cnt_next       = '0;
                            sh_invld_cnt_next = '0;
                        end else if (sh_cnt_reg == SH_W'(LOCK_COUNT - 1)) begin
                            lock_next         = 1'b1;
                            sh_cnt_next       = '0;
                            sh_invld_cnt_next = '0;
                        end else begin
                            sh_cnt_next = sh_cnt_reg + SH_W'(1);
                        end
                    end else begin
                        // Unlock is tested before window end so it wins on the last header.
                        if (hdr_bad && sh_invld_cnt_reg == IV_W'(UNLOCK_INVALID - 1)) begin
                            lock_next         = 1'b0;
                            state_next        = SLIP;
                            slip_next         = 1'b1;
                            sh_cnt_next       = '0;
                            sh_invld_cnt_next = '0;
                        end else if (sh_cnt_reg == SH_W'(LOCK_COUNT - 1)) begin
                            sh_cnt_next       = '0;
                            sh_invld_cnt_next = '0;
                        end else begin
                            sh_cnt_next = sh_cnt_reg + SH_W'(1);
                            if (hdr_bad) begin
                                sh_invld_cnt_next = sh_invld_cnt_reg + IV_W'(1);
                            end
                        end
                    end
                end
            end
            SLIP: begin
                state_next        = WAIT;
                wait_cnt_next     = '0;
                sh_cnt_next       = '0;
                sh_invld_cnt_next = '0;
            end
            WAIT: begin
                if (i_valid) begin
                    if (wait_cnt_reg == WT_W'(SLIP_WAIT - 1)) begin
                        state_next    = TEST_SH;
                        wait_cnt_next = '0;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + WT_W'(1);
                    end
                end
            end
            default: state_next = LOCK_INIT;
        endcase
    end

    // The BER window only runs across cycles where lock is held before and after the edge.
    always_comb begin
        win_cnt_next = win_cnt_reg;
        ber_cnt_next = ber_cnt_reg;
        hi_ber_next  = hi_ber_reg;
        ber_sum      = ber_cnt_reg;
        if (!lock_reg || !lock_next) begin
            win_cnt_next = '0;
            ber_cnt_next = '0;
            hi_ber_next  = 1'b0;
        end else begin
            if (hdr_bad && ber_cnt_reg != BER_W'(BER_THRESHOLD)) begin
                ber_sum = ber_cnt_reg + BER_W'(1);
            end
            if (win_cnt_reg == WIN_W'(BER_WINDOW - 1)) begin
                win_cnt_next = '0;
                ber_cnt_next = '0;
                hi_ber_next  = (ber_sum == BER_W'(BER_THRESHOLD));
            end else begin
                win_cnt_next = win_cnt_reg + WIN_W'(1);
                ber_cnt_next = ber_sum;
                if (ber_sum == BER_W'(BER_THRESHOLD)) begin
                    hi_ber_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge xver_rx_clk) begin
        if (rx_reset) begin
            state_reg        <= LOCK_INIT;
            sh_cnt_reg       <= '0;
            sh_invld_cnt_reg <= '0;
            wait_cnt_reg     <= '0;
            lock_reg         <= 1'b0;
            slip_reg         <= 1'b0;
            win_cnt_reg      <= '0;
            ber_cnt_reg      <= '0;
            hi_ber_reg       <= 1'b0;
            ber_count_reg    <= '0;
        end else begin
            state_reg        <= state_next;
            sh_cnt_reg       <= sh_cnt_next;
            sh_invld_cnt_reg <= sh_invld_cnt_next;
            wait_cnt_reg     <= wait_cnt_next;
            lock_reg         <= lock_next;
            slip_reg         <= slip_next;
            win_cnt_reg      <= win_cnt_next;
            ber_cnt_reg      <= ber_cnt_next;
            hi_ber_reg       <= hi_ber_next;
            if (i_ber_count_clr) begin
                ber_count_reg <= '0;
            end else if (hdr_bad && ber_count_reg != 8'hFF) begin
                ber_count_reg <= ber_count_reg + 8'd1;
            end
        end
    end

`ifdef PCS_LOCK_STATS_EN
    logic [15:0] slip_count_reg;
    logic [15:0] lock_loss_count_reg;

    always_ff @(posedge xver_rx_clk) begin
        if (rx_reset || i_ber_count_clr) begin
            slip_count_reg      <= '0;
            lock_loss_count_reg <= '0;
        end else begin
            if (slip_next && slip_count_reg != 16'hFFFF) begin
                slip_count_reg <= slip_count_reg + 16'd1;
            end
            if (lock_reg && !lock_next && lock_loss_count_reg != 16'hFFFF) begin
                lock_loss_count_reg <= lock_loss_count_reg + 16'd1;
            end
        end
    end

    assign o_slip_count      = slip_count_reg;
    assign o_lock_loss_count = lock_loss_count_reg;
`else
    assign o_slip_count      = 16'd0;
    assign o_lock_loss_count = 16'd0;
`endif

    assign o_slip        = slip_reg;
    assign o_block_lock  = lock_reg;
    assign o_hi_ber      = hi_ber_reg;
    assign o_block_start = block_start;
    assign o_ber_count   = ber_count_reg;

endmodule

// File: tb/tb_pcs_rx_block_sync.sv
// Bench for pcs_rx_block_sync: a 64b and a 32b instance share one randomized stream
// and are scored every cycle against a header-history reference model.
module tb_pcs_rx_block_sync;

    localparam int LOCK_COUNT     = 64;
    localparam int UNLOCK_INVALID = 16;
    localparam int SLIP_WAIT      = 32;
    localparam int BER_WINDOW     = 100;
    localparam int BER_THRESHOLD  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rx_reset = 1'b1;
    logic       valid    = 1'b0;
    logic       clr      = 1'b0;
    logic [1:0] hdr      = 2'b00;

    logic [1:0]        slip_w, lock_w, hi_w, start_w;
    logic [1:0][7:0]   berc_w;
    logic [1:0][15:0]  slipc_w, lossc_w;

    pcs_rx_block_sync #(
        .DATA_WIDTH(64), .LOCK_COUNT(LOCK_COUNT), .UNLOCK_INVALID(UNLOCK_INVALID),
        .SLIP_WAIT(SLIP_WAIT), .BER_WINDOW(BER_WINDOW), .BER_THRESHOLD(BER_THRESHOLD)
    ) dut64 (
        .xver_rx_clk(clk), .rx_reset(rx_reset), .i_header(hdr), .i_valid(valid),
        .o_slip(slip_w[0]), .o_block_lock(lock_w[0]), .o_hi_ber(hi_w[0]),
        .o_block_start(start_w[0]), .o_ber_count(berc_w[0]), .i_ber_count_clr(clr),
        .o_slip_count(slipc_w[0]), .o_lock_loss_count(lossc_w[0])
    );

    pcs_rx_block_sync #(
        .DATA_WIDTH(32), .LOCK_COUNT(LOCK_COUNT), .UNLOCK_INVALID(UNLOCK_INVALID),
        .SLIP_WAIT(SLIP_WAIT), .BER_WINDOW(BER_WINDOW), .BER_THRESHOLD(BER_THRESHOLD)
    ) dut32 (
        .xver_rx_clk(clk), .rx_reset(rx_reset), .i_header(hdr), .i_valid(valid),
        .o_slip(slip_w[1]), .o_block_lock(lock_w[1]), .o_hi_ber(hi_w[1]),
        .o_block_start(start_w[1]), .o_ber_count(berc_w[1]), .i_ber_count_clr(clr),
        .o_slip_count(slipc_w[1]), .o_lock_loss_count(lossc_w[1])
    );

    // Reference model: mode 0=init 1=testing headers 2=slip 3=hold-off
    int m_phase [2];
    int m_mode  [2];
    int m_n     [2];
    int m_hold  [2];
    int m_lcyc  [2];
    int m_werr  [2];
    bit m_hist  [2][LOCK_COUNT];
    bit e_slip  [2];
    bit e_lock  [2];
    bit e_hi    [2];
    bit e_start [2];
    int e_berc  [2];
    int e_slipc [2];
    int e_lossc [2];

    int checks    = 0;
    int errors    = 0;
    int cycle_cnt = 0;
    int n_slip64  = 0;

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cycle_cnt);
        end
    endtask

    task automatic model_step(input int k, input int w, input bit r, input bit v,
                              input logic [1:0] h, input bit c);
        bit st, ev, bad, lk0, new_lock, new_slip;
        int nbad;
        if (r) begin
            m_phase[k] = 0; m_mode[k] = 0; m_n[k] = 0; m_hold[k] = 0;
            m_lcyc[k] = 0; m_werr[k] = 0;
            e_slip[k] = 0; e_lock[k] = 0; e_hi[k] = 0; e_start[k] = 1;
            e_berc[k] = 0; e_slipc[k] = 0; e_lossc[k] = 0;
            return;
        end
        st       = (w == 64) || (m_phase[k] == 0);
        ev       = v && st;
        bad      = ev && !(h == 2'b01 || h == 2'b10);
        lk0      = e_lock[k];
        new_lock = lk0;
        new_slip = 0;
        case (m_mode[k])
            0: begin m_mode[k] = 1; m_n[k] = 0; end
            1: if (ev) begin
                m_hist[k][m_n[k]] = bad;
                m_n[k]++;
                nbad = 0;
                for (int i = 0; i < m_n[k]; i++) nbad += int'(m_hist[k][i]);
                if (!lk0) begin
                    if (bad) new_slip = 1;
                    else if (m_n[k] == LOCK_COUNT) begin new_lock = 1; m_n[k] = 0; end
                end else begin
                    if (nbad == UNLOCK_INVALID) begin new_lock = 0; new_slip = 1; end
                    else if (m_n[k] == LOCK_COUNT) m_n[k] = 0;
                end
                if (new_slip) begin m_n[k] = 0; m_mode[k] = 2; end
            end
            2: begin m_mode[k] = 3; m_hold[k] = SLIP_WAIT; end
            default: if (v) begin
                m_hold[k]--;
                if (m_hold[k] == 0) begin m_mode[k] = 1; m_n[k] = 0; end
            end
        endcase
        if (e_slip[k]) m_phase[k] = 0;
        else if (v) m_phase[k] = 1 - m_phase[k];
        if (c) e_berc[k] = 0;
        else if (bad && e_berc[k] < 255) e_berc[k]++;
        if (lk0 && new_lock) begin
            if (bad) m_werr[k]++;
            if (m_lcyc[k] % BER_WINDOW == BER_WINDOW - 1) begin
                e_hi[k]   = (m_werr[k] >= BER_THRESHOLD);
                m_werr[k] = 0;
            end else if (m_werr[k] >= BER_THRESHOLD) begin
                e_hi[k] = 1;
            end
            m_lcyc[k]++;
        end else begin
            m_lcyc[k] = 0; m_werr[k] = 0; e_hi[k] = 0;
        end
`ifdef PCS_LOCK_STATS_EN
        if (c) begin
            e_slipc[k] = 0; e_lossc[k] = 0;
        end else begin
            if (new_slip && e_slipc[k] < 65535) e_slipc[k]++;
            if (lk0 && !new_lock && e_lossc[k] < 65535) e_lossc[k]++;
        end
`endif
        e_slip[k]  = new_slip;
        e_lock[k]  = new_lock;
        e_start[k] = (w == 64) || (m_phase[k] == 0);
    endtask

    task automatic step(input bit r, input bit v, input logic [1:0] h, input bit c);
        string sfx;
        if (errors > 200) return;
        @(negedge clk);
        rx_reset = r; valid = v; hdr = h; clr = c;
        model_step(0, 64, r, v, h, c);
        model_step(1, 32, r, v, h, c);
        @(posedge clk);
        #1;
        cycle_cnt++;
        if (slip_w[0]) n_slip64++;
        for (int k = 0; k < 2; k++) begin
            sfx = (k == 0) ? "64" : "32";
            check({"slip", sfx},  int'(slip_w[k]),  int'(e_slip[k]));
            check({"lock", sfx},  int'(lock_w[k]),  int'(e_lock[k]));
            check({"hiber", sfx}, int'(hi_w[k]),    int'(e_hi[k]));
            check({"start", sfx}, int'(start_w[k]), int'(e_start[k]));
            check({"berc", sfx},  int'(berc_w[k]),  e_berc[k]);
            check({"slipc", sfx}, int'(slipc_w[k]), e_slipc[k]);
            check({"lossc", sfx}, int'(lossc_w[k]), e_lossc[k]);
        end
    endtask

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    endfunction

    task automatic run_random(input string name, input int n, input int valid_pct,
                              input int bad_pct, input int clr_pm);
        bit v, c;
        for (int i = 0; i < n; i++) begin
            v = ($urandom_range(0, 99) < valid_pct);
            c = ($urandom_range(0, 999) < clr_pm);
            step(0, v, ($urandom_range(0, 99) < bad_pct) ? bad_hdr() : good_hdr(), c);
        end
        $display("[tb] %s: %0d cycles lock64=%0d lock32=%0d hiber64=%0d berc64=%0d",
                 name, n, lock_w[0], lock_w[1], hi_w[0], berc_w[0]);
    endtask

    task automatic do_reset();
        step(1, 0, 2'b00, 0);
        step(1, 1, 2'b11, 0);
        step(0, 0, 2'b00, 0);
    endtask

    initial begin
        // Reset values
        do_reset();
        check("reset_start64", int'(start_w[0]), 1);
        check("reset_lock64", int'(lock_w[0]), 0);
        $display("[tb] reset: lock64=%0d start32=%0d", lock_w[0], start_w[1]);

        // Clean lock from reset; no slip on the 64b lane
        n_slip64 = 0;
        for (int i = 0; i < LOCK_COUNT + 1; i++) step(0, 1, good_hdr(), 0);
        check("lock_after_64_hdrs", int'(lock_w[0]), 1);
        check("no_slip_clean64", n_slip64, 0);
        $display("[tb] clean_lock: lock64=%0d slips64=%0d", lock_w[0], n_slip64);

        // Unlocked slip on the 10th block, ignored headers during hold-off, relock
        do_reset();
        n_slip64 = 0;
        for (int i = 0; i < 9; i++) step(0, 1, good_hdr(), 0);
        step(0, 1, 2'b00, 0);
        check("slip_pulse64", int'(slip_w[0]), 1);
        step(0, 1, bad_hdr(), 0);
        check("slip_one_cycle64", int'(slip_w[0]), 0);
        for (int i = 0; i < SLIP_WAIT; i++) step(0, 1, bad_hdr(), 0);
        for (int i = 0; i < LOCK_COUNT; i++) step(0, 1, good_hdr(), 0);
        check("relock64", int'(lock_w[0]), 1);
        check("single_slip64", n_slip64, 1);
        $display("[tb] slip_relock: lock64=%0d slips64=%0d", lock_w[0], n_slip64);

        // 32b lane: garbage only on second words of each block has no effect
        do_reset();
        for (int i = 0; i < 2 * LOCK_COUNT + 4; i++) step(0, 1, good_hdr(), 0);
        for (int i = 0; i < 300; i++)
            step(0, ($urandom_range(0, 99) < 60), e_start[1] ? good_hdr() : bad_hdr(), 0);
        check("odd_garbage_lock32", int'(lock_w[1]), 1);
        $display("[tb] odd_garbage: lock32=%0d", lock_w[1]);

        // BER: sparse errors while locked, then clean windows
        do_reset();
        for (int i = 0; i < 200; i++) step(0, 1, good_hdr(), 0);
        for (int i = 0; i < 60; i++) step(0, 1, (i % 10 == 3) ? bad_hdr() : good_hdr(), 0);
        for (int i = 0; i < 250; i++) step(0, 1, good_hdr(), 0);
        check("hiber_cleared64", int'(hi_w[0]), 0);
        $display("[tb] ber_window: lock64=%0d hiber64=%0d", lock_w[0], hi_w[0]);

        // Three lock losses
        do_reset();
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 200; i++) step(0, 1, good_hdr(), 0);
            for (int i = 0; i < 40; i++) step(0, 1, bad_hdr(), 0);
        end
`ifdef PCS_LOCK_STATS_EN
        check("lock_loss3_64", int'(lossc_w[0]), 3);
`else
        check("lock_loss_off64", int'(lossc_w[0]), 0);
`endif
        $display("[tb] lock_losses: lossc64=%0d lossc32=%0d", lossc_w[0], lossc_w[1]);

        // Error counter saturation and clear-over-increment
        for (int i = 0; i < 600; i++) step(0, 1, bad_hdr(), 0);
        check("berc_sat64", int'(berc_w[0]), 255);
        step(0, 1, 2'b00, 0);
        check("berc_hold64", int'(berc_w[0]), 255);
        step(0, 1, 2'b11, 1);
        check("berc_clr64", int'(berc_w[0]), 0);
        check("berc_clr32", int'(berc_w[1]), 0);
        $display("[tb] ber_count_sat: berc64=%0d berc32=%0d", berc_w[0], berc_w[1]);

        // Randomized traffic at several error rates
        run_random("rand_p0",  1500, 80, 0,  5);
        run_random("rand_p2",  1500, 80, 2,  5);
        run_random("rand_p6",  1500, 70, 6,  5);
        run_random("rand_p15", 1500, 90, 15, 5);
        run_random("rand_p30", 1000, 80, 30, 5);

        // Reset in the middle of locked operation
        for (int i = 0; i < 200; i++) step(0, 1, good_hdr(), 0);
        step(1, 1, 2'b00, 0);
        check("midreset_lock64", int'(lock_w[0]), 0);
        check("midreset_slip32", int'(slip_w[1]), 0);
        step(0, 1, good_hdr(), 0);
        $display("[tb] mid_reset: lock64=%0d start32=%0d", lock_w[0], start_w[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
